idma_desc64_ch_arbiter: RTL and testbench
=========================================

# idma_desc64_ch_arbiter

Round-robin scheduler that lets several software or hardware channels share the single descriptor submission port of the 64-bit descriptor frontend. It arbitrates between per-channel descriptor-address requests and presents one registered address stream to the frontend. It tracks submitted descriptors in order, and routes each completion pulse from the DMA back to the channel that owns it. It sits between the channel request logic and the frontend's descriptor-address write path.

## Interface
- NumChannels, 4, number of requesting channels (2..16)
- AddrWidth, 64, descriptor address width
- MaxInflight, 8, maximum descriptors submitted but not yet completed (power of two, 2..32)
- Derived: ChW = $clog2(NumChannels), CntW = $clog2(MaxInflight+1)

Ports:
- clk_i  in  1  clock; all logic is on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- ch_addr_i  in  NumChannels*AddrWidth  descriptor address per channel; channel k occupies bits [k*AddrWidth +: AddrWidth]
- ch_valid_i  in  NumChannels  per-channel request valid
- ch_ready_o  out  NumChannels  per-channel grant; combinational and one-hot or zero
- ch_done_o  out  NumChannels  registered one-cycle completion pulse to the owning channel
- submit_addr_o  out  AddrWidth  registered descriptor address to the frontend
- submit_valid_o  out  1  registered valid
- submit_ready_i  in  1  frontend accepts the address
- done_i  in  1  one-cycle pulse per completed descriptor; every submitted descriptor must request an IRQ
- inflight_o  out  CntW  number of granted, not-yet-completed descriptors
- busy_o  out  1  inflight_o != 0
- err_o  out  1  sticky; set when done_i arrives while inflight_o == 0

## Operation
- Output stage: a single register holding {submit_valid_o, submit_addr_o}. It loads on a grant and clears on submit_valid_o && submit_ready_i with no grant in the same cycle. submit_addr_o is stable while submit_valid_o is high and submit_ready_i is low.
- Grant enable: (!submit_valid_o || submit_ready_i) && inflight_o < MaxInflight. A pop in the same cycle is not credited.
- Arbitration: pick the lowest index k >= rr_ptr with ch_valid_i[k] set, wrapping past NumChannels-1 to 0. Assert ch_ready_o[k] in the same cycle. On a grant, rr_ptr <= (k+1) mod NumChannels. rr_ptr holds when there is no grant.
- Ownership FIFO: depth MaxInflight, width ChW. A grant pushes k. done_i pops the head h and sets ch_done_o[h] for exactly the next cycle. Push and pop may occur in the same cycle. Read and write pointers wrap modulo MaxInflight.
- inflight_o: +1 on a grant, -1 on a valid pop, unchanged when both occur. It never exceeds MaxInflight.
- done_i with an empty FIFO: no pop, no ch_done_o pulse, err_o <= 1. Only reset clears err_o.
- Channels must hold ch_valid_i and ch_addr_i until they are granted. The block does not check this.

## Timing
- Reset values: ch_done_o = 0, submit_valid_o = 0, submit_addr_o = 0, inflight_o = 0, busy_o = 0, err_o = 0, rr_ptr = 0, FIFO pointers = 0. ch_ready_o is 0 while in reset.
- Request-to-output latency: a grant in cycle t gives submit_valid_o = 1 in cycle t+1.
- Back-to-back throughput: with submit_ready_i held high, one grant per cycle.
- Completion latency: done_i in cycle t gives ch_done_o pulse in cycle t+1.
- Full condition: when inflight_o == MaxInflight, all ch_ready_o are 0, even if done_i is high that cycle. Grants resume the cycle after the pop.
- Reset asserted mid-operation: all state clears immediately. Pending descriptors are forgotten, and done_i pulses arriving after reset set err_o.

## Test plan
- Single channel: ch_valid_i = 4'b0010, ch_addr_i[1] = 0x1000, submit_ready_i = 1 -> ch_ready_o = 4'b0010 in cycle 0; submit_addr_o = 0x1000 and inflight_o = 1 in cycle 1. Then done_i -> ch_done_o = 4'b0010 one cycle later, inflight_o = 0.
- Round robin: all four channels valid continuously, ready = 1 -> grant order 0,1,2,3,0,1,2,3. Completions return in the same order on ch_done_o.
- Backpressure: submit_ready_i = 0 for 5 cycles with channel 2 granted -> submit_addr_o stable, no further grants. After ready rises, the next grant goes to channel 3 if it is valid.
- Full: MaxInflight = 8, issue 8 grants with no done_i -> ch_ready_o = 0, inflight_o = 8. One done_i -> a grant is allowed in the following cycle.
- Simultaneous: a grant and done_i in the same cycle at inflight_o = 3 -> inflight_o stays 3, and the correct owner pulses.
- Spurious completion: done_i at inflight_o = 0 -> err_o = 1 stays set, ch_done_o = 0. Reset -> err_o = 0.

Source files
------------

// File: rtl/idma_desc64_ch_arbiter.sv
// Round-robin arbiter that shares the descriptor submission port between
// channels. It also tracks descriptor ownership in order so that completions
// can be routed back to the channel that submitted them.
module idma_desc64_ch_arbiter #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned MaxInflight = 8,
  localparam int unsigned ChW  = $clog2(NumChannels),
  localparam int unsigned CntW = $clog2(MaxInflight + 1),
  localparam int unsigned PtrW = $clog2(MaxInflight)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels*AddrWidth-1:0] ch_addr_i,
  input  logic [NumChannels-1:0]           ch_valid_i,
  output logic [NumChannels-1:0]           ch_ready_o,
  output logic [NumChannels-1:0]           ch_done_o,
  output logic [AddrWidth-1:0]             submit_addr_o,
  output logic                             submit_valid_o,
  input  logic                             submit_ready_i,
  input  logic                             done_i,
  output logic [CntW-1:0]                  inflight_o,
  output logic                             busy_o,
  output logic                             err_o
);

  logic [AddrWidth-1:0] addr_arr [NumChannels];

  logic [ChW-1:0]       rr_q;
  logic [AddrWidth-1:0] sub_addr_q;
  logic                 sub_valid_q;
  logic [CntW-1:0]      infl_q;
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [ChW-1:0]       own_q [MaxInflight];
  logic [NumChannels-1:0] done_q;
  logic                 err_q;

  logic                 gnt_en, gnt_found, gnt, pop;
  logic [ChW-1:0]       gnt_idx;

  // Split the flat address bus into one entry per channel.
  for (genvar g = 0; g < NumChannels; g++) begin : g_addr
    assign addr_arr[g] = ch_addr_i[g*AddrWidth +: AddrWidth];
  end

  // A grant needs room in the output register and a free in-flight slot.
  // A completion in the same cycle does not free a slot until the next one.
  assign gnt_en = rst_ni && (!sub_valid_q || submit_ready_i) &&
                  (infl_q < CntW'(MaxInflight));

  // Search from rr_q upward, wrapping, for the first requesting channel.
  always_comb begin
    logic [ChW:0] sum;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int i = 0; i < NumChannels; i++) begin
      sum = {1'b0, rr_q} + (ChW+1)'(i);
      if (sum >= (ChW+1)'(NumChannels)) sum = sum - (ChW+1)'(NumChannels);
      if (!gnt_found && ch_valid_i[sum[ChW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[ChW-1:0];
      end
    end
  end

  assign gnt        = gnt_en && gnt_found;
  assign ch_ready_o = gnt ? (NumChannels'(1) << gnt_idx) : '0;

  // Only completions with a recorded owner pop; the rest raise the error.
  assign pop = done_i && (infl_q != '0);

  // Round-robin pointer moves past the winner; holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (gnt) begin
      rr_q <= (gnt_idx == ChW'(NumChannels - 1)) ? '0 : gnt_idx + ChW'(1);
    end
  end

  // Output stage: load on grant, empty once the frontend takes the address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_valid_q <= 1'b0;
      sub_addr_q  <= '0;
    end else if (gnt) begin
      sub_valid_q <= 1'b1;
      sub_addr_q  <= addr_arr[gnt_idx];
    end else if (sub_valid_q && submit_ready_i) begin
      sub_valid_q <= 1'b0;
      sub_addr_q  <= '0;
    end
  end

  // Ownership FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (gnt) own_q[wptr_q] <= gnt_idx;
  end

  // FIFO pointers and in-flight count; depth is a power of two so pointers
  // wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      infl_q <= '0;
    end else begin
      if (gnt) wptr_q <= wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      case ({gnt, pop})
        2'b10:   infl_q <= infl_q + CntW'(1);
        2'b01:   infl_q <= infl_q - CntW'(1);
        default: infl_q <= infl_q;
      endcase
    end
  end

  // Completion pulse to the head owner, and the sticky spurious-done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= pop ? (NumChannels'(1) << own_q[rptr_q]) : '0;
      if (done_i && (infl_q == '0)) err_q <= 1'b1;
    end
  end

  assign ch_done_o      = done_q;
  assign submit_addr_o  = sub_addr_q;
  assign submit_valid_o = sub_valid_q;
  assign inflight_o     = infl_q;
  assign busy_o         = (infl_q != '0);
  assign err_o          = err_q;

endmodule

// File: tb/tb_idma_desc64_ch_arbiter.sv
// Directed and randomized checks of the channel arbiter against a
// queue-based model of grant order, output register and ownership.
module tb_idma_desc64_ch_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int MI = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N-1:0]    ch_valid = '0;
  logic [N-1:0]    ch_ready, ch_done;
  logic [AW-1:0]   sub_addr;
  logic            sub_valid;
  logic            sub_ready = 1'b0;
  logic            done = 1'b0;
  logic [3:0]      inflight;
  logic            busy, err;

  idma_desc64_ch_arbiter #(.NumChannels(N), .AddrWidth(AW), .MaxInflight(MI)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ch_addr_i(ch_addr), .ch_valid_i(ch_valid),
    .ch_ready_o(ch_ready), .ch_done_o(ch_done), .submit_addr_o(sub_addr),
    .submit_valid_o(sub_valid), .submit_ready_i(sub_ready), .done_i(done),
    .inflight_o(inflight), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int ntot = 0, nfail = 0;

  // reference model state
  bit          m_valid;
  logic [63:0] m_addr;
  logic [3:0]  m_done;
  int          q[$];
  int          rr;
  bit          m_err;
  int          g_last;
  logic [3:0]  last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_addr = '0; m_done = '0; q.delete(); rr = 0; m_err = 0; g_last = -1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".valid"}, 64'(sub_valid), 64'(m_valid));
    chk({tag, ".addr"}, sub_addr, m_addr);
    chk({tag, ".done"}, 64'(ch_done), 64'(m_done));
    chk({tag, ".inflight"}, 64'(inflight), 64'(q.size()));
    chk({tag, ".busy"}, 64'(busy), 64'(q.size() != 0));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
  endtask

  // One clock cycle: check the combinational grant, advance the model, then
  // check the registered outputs just after the edge.
  task automatic step();
    int k;
    bit en;
    logic [3:0] er;
    #1;
    k  = -1;
    en = (!m_valid || sub_ready) && (q.size() < MI);
    if (en)
      for (int i = 0; i < N; i++) begin
        int c;
        c = (rr + i) % N;
        if (k < 0 && ch_valid[c]) k = c;
      end
    er = (k >= 0) ? 4'(1 << k) : 4'h0;
    last_rdy = ch_ready;
    chk("ch_ready", 64'(ch_ready), 64'(er));
    @(posedge clk);
    m_done = '0;
    if (done) begin
      if (q.size() > 0) begin
        m_done = 4'(1 << q[0]);
        void'(q.pop_front());
      end else m_err = 1;
    end
    if (k >= 0) begin
      q.push_back(k);
      rr = (k + 1) % N;
      m_valid = 1;
      m_addr = ch_addr[k*AW +: AW];
    end else if (m_valid && sub_ready) begin
      m_valid = 0;
      m_addr = '0;
    end
    g_last = k;
    #1;
    chk_regs("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    chk("rst.ch_ready", 64'(ch_ready), 64'h0);
    chk_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    ch_valid = '0;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      done = 1'b1; step(); done = 1'b0;
    end
    step();
  endtask

  task automatic set_addr(input int c, input logic [63:0] a);
    ch_addr[c*AW +: AW] = a;
  endtask

  initial begin
    logic [63:0] a2;
    model_reset();
    ch_valid = '1;
    do_reset();

    // single channel
    ch_valid = 4'b0010; set_addr(1, 64'h1000); sub_ready = 1'b1;
    step();
    chk("single.grant", 64'(last_rdy), 64'h2);
    chk("single.addr", sub_addr, 64'h1000);
    chk("single.inflight", 64'(inflight), 64'd1);
    ch_valid = '0;
    done = 1'b1; step(); done = 1'b0;
    chk("single.done", 64'(ch_done), 64'h2);
    chk("single.inflight0", 64'(inflight), 64'd0);

    // round robin fill up to the in-flight limit
    do_reset();
    for (int c = 0; c < N; c++) set_addr(c, 64'($urandom));
    ch_valid = '1; sub_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr.order", 64'(last_rdy), 64'(1 << (i % 4)));
      set_addr(i % 4, {32'($urandom), 32'($urandom)});
    end
    step();
    chk("full.ready", 64'(last_rdy), 64'h0);
    chk("full.inflight", 64'(inflight), 64'd8);
    done = 1'b1; step(); done = 1'b0;
    chk("full.ready_with_done", 64'(last_rdy), 64'h0);
    step();
    chk("full.resume", 64'(last_rdy), 64'h1);
    ch_valid = '0;
    for (int i = 0; i < 8; i++) begin
      done = 1'b1; step(); done = 1'b0;
      chk("rr.done_order", 64'(ch_done), 64'(1 << ((i + 1) % 4)));
    end
    step();

    // backpressure
    sub_ready = 1'b0; ch_valid = 4'b0100; set_addr(2, 64'hABCD_0002); set_addr(3, 64'hABCD_0003);
    step();
    chk("bp.grant2", 64'(last_rdy), 64'h4);
    a2 = sub_addr;
    ch_valid = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.nogrant", 64'(last_rdy), 64'h0);
      chk("bp.stable", sub_addr, a2);
    end
    sub_ready = 1'b1;
    step();
    chk("bp.grant3", 64'(last_rdy), 64'h8);
    chk("bp.addr3", sub_addr, 64'hABCD_0003);
    drain();

    // simultaneous grant and completion at three in flight
    ch_valid = '1;
    for (int i = 0; i < 3; i++) step();
    chk("sim.pre", 64'(inflight), 64'd3);
    done = 1'b1; step(); done = 1'b0;
    chk("sim.inflight", 64'(inflight), 64'd3);
    chk("sim.owner", 64'(ch_done), 64'h1);
    drain();

    // spurious completion
    done = 1'b1; step(); done = 1'b0;
    chk("spur.err", 64'(err), 64'd1);
    chk("spur.done", 64'(ch_done), 64'h0);
    step(); step();
    chk("spur.sticky", 64'(err), 64'd1);
    do_reset();
    chk("spur.cleared", 64'(err), 64'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N; c++)
        if (!ch_valid[c] && ($urandom % 2 == 0)) begin
          ch_valid[c] = 1'b1;
          set_addr(c, {32'($urandom), 32'($urandom)});
        end
      sub_ready = ($urandom % 4 != 0);
      done = (q.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 100 == 0);
      step();
      done = 1'b0;
      if (g_last >= 0) ch_valid[g_last] = 1'b0;
    end

    // reset mid-operation, then a stale completion
    ch_valid = '1;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    ch_valid = '0;
    done = 1'b1; step(); done = 1'b0;
    chk("post_rst.err", 64'(err), 64'd1);
    chk("post_rst.done", 64'(ch_done), 64'h0);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end
endmodule
